// File: rtl/freelist.sv
// Physical-register free list: bitmap of free tags, offers up to N lowest free tags per cycle.
// Latency: offers are combinational from state; pops/returns/recovery land on the next clock edge.
// Backpressure: none; excess pop requests are clamped to the number of valid offers.
module freelist #(
    parameter int N            = 3,
    parameter int PR_COUNT     = 64,
    parameter int ARCH_COUNT   = 32,
    parameter int EXCLUDE_ZERO = 1,
    localparam int TW  = (PR_COUNT > 1) ? $clog2(PR_COUNT) : 1,
    localparam int CW  = $clog2(N + 1),
    localparam int FCW = $clog2(PR_COUNT + 1)
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [CW-1:0]                    AllocPopCount,
    output logic [N-1:0][TW-1:0]             FreeReg,
    output logic [FCW-1:0]                   free_count,
    output logic [CW-1:0]                    FreeSlotsForN,
    input  logic [N-1:0]                     RetireEN,
    input  logic [N-1:0][TW-1:0]             RetireReg,
    input  logic                             BPRecoverEN,
    input  logic [ARCH_COUNT-1:0][TW-1:0]    archi_maptable
);

    logic [PR_COUNT-1:0] free_vec;
    logic [PR_COUNT-1:0] free_nxt;
    logic [PR_COUNT-1:0] reset_img;
    logic [PR_COUNT-1:0] recover_img;

    // Tags below ARCH_COUNT hold the identity architectural mapping out of reset.
    always_comb begin
        reset_img = '0;
        for (int i = 0; i < PR_COUNT; i++) begin
            if (i >= ARCH_COUNT && !(i == 0 && EXCLUDE_ZERO != 0))
                reset_img[i] = 1'b1;
        end
    end

    always_comb begin
        recover_img = '1;
        for (int a = 0; a < ARCH_COUNT; a++) begin
            if (int'(archi_maptable[a]) < PR_COUNT)
                recover_img[archi_maptable[a]] = 1'b0;
        end
        if (EXCLUDE_ZERO != 0)
            recover_img[0] = 1'b0;
    end

    always_comb begin
        free_count = '0;
        for (int i = 0; i < PR_COUNT; i++)
            free_count = free_count + FCW'(free_vec[i]);
    end

    always_comb begin
        if (int'(free_count) >= N)
            FreeSlotsForN = CW'(N);
        else
            FreeSlotsForN = CW'(free_count);
    end

    // Priority pick: lane k takes the k-th lowest set bit; unused lanes stay zero.
    always_comb begin
        int cnt;
        cnt     = 0;
        FreeReg = '0;
        for (int i = 0; i < PR_COUNT; i++) begin
            if (free_vec[i] && !(i == 0 && EXCLUDE_ZERO != 0)) begin
                for (int k = 0; k < N; k++) begin
                    if (cnt == k)
                        FreeReg[k] = TW'(i);
                end
                cnt = cnt + 1;
            end
        end
    end

    // Returns are applied after pops so a tag both popped and returned ends up free.
    always_comb begin
        free_nxt = free_vec;
        for (int k = 0; k < N; k++) begin
            if (k < int'(AllocPopCount) && k < int'(FreeSlotsForN))
                free_nxt[FreeReg[k]] = 1'b0;
        end
        for (int k = 0; k < N; k++) begin
            if (RetireEN[k] && int'(RetireReg[k]) < PR_COUNT &&
                !(RetireReg[k] == '0 && EXCLUDE_ZERO != 0))
                free_nxt[RetireReg[k]] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            free_vec <= reset_img;
        else if (BPRecoverEN)
            free_vec <= recover_img;
        else
            free_vec <= free_nxt;
    end

endmodule

// File: tb/tb_freelist.sv
// Directed bench for freelist with an expected-value queue checked against DUT outputs.
module tb_freelist;
    localparam int N = 3, PR_COUNT = 64, ARCH_COUNT = 32;
    localparam int TW = 6, CW = 2, FCW = 7;

    logic                          clock = 1'b0;
    logic                          reset;
    logic [CW-1:0]                 AllocPopCount;
    logic [N-1:0][TW-1:0]          FreeReg;
    logic [FCW-1:0]                free_count;
    logic [CW-1:0]                 FreeSlotsForN;
    logic [N-1:0]                  RetireEN;
    logic [N-1:0][TW-1:0]          RetireReg;
    logic                          BPRecoverEN;
    logic [ARCH_COUNT-1:0][TW-1:0] archi_maptable;

    freelist #(.N(N), .PR_COUNT(PR_COUNT), .ARCH_COUNT(ARCH_COUNT), .EXCLUDE_ZERO(1)) dut (
        .clock(clock), .reset(reset), .AllocPopCount(AllocPopCount), .FreeReg(FreeReg),
        .free_count(free_count), .FreeSlotsForN(FreeSlotsForN), .RetireEN(RetireEN),
        .RetireReg(RetireReg), .BPRecoverEN(BPRecoverEN), .archi_maptable(archi_maptable)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) e = 'x;
        else e = exp_q.pop_front();
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic offer(input string tag, input int c, input int s,
                         input int l0, input int l1, input int l2);
        push(32'(c)); push(32'(s)); push(32'(l0)); push(32'(l1)); push(32'(l2)); push(32'd0);
        check({tag, ".count"}, 32'(free_count));
        check({tag, ".slots"}, 32'(FreeSlotsForN));
        check({tag, ".lane0"}, 32'(FreeReg[0]));
        check({tag, ".lane1"}, 32'(FreeReg[1]));
        check({tag, ".lane2"}, 32'(FreeReg[2]));
        check({tag, ".xstate"}, 32'($isunknown(FreeReg)));
    endtask

    task automatic retire3(input logic [2:0] en, input int t0, input int t1, input int t2);
        RetireEN     = en;
        RetireReg[0] = TW'(t0);
        RetireReg[1] = TW'(t1);
        RetireReg[2] = TW'(t2);
    endtask

    initial begin
        int rem, s, dut_granted, dut_cycles;
        reset = 1'b1; AllocPopCount = '0; BPRecoverEN = 1'b0;
        RetireEN = '0; RetireReg = '0; archi_maptable = '0;
        tick();
        reset = 1'b0;
        offer("reset", 32, 3, 32, 33, 34);

        // Drain by consuming every valid offer each cycle.
        dut_granted = 0; dut_cycles = 0;
        for (int c = 0; c < 20; c++) begin
            if (FreeSlotsForN == 0) break;
            rem = 32 - 3 * c;
            if (rem < 0) rem = 0;
            s = (rem < 3) ? rem : 3;
            offer("drain", rem, s, (s > 0) ? 32 + 3 * c : 0,
                  (s > 1) ? 33 + 3 * c : 0, (s > 2) ? 34 + 3 * c : 0);
            dut_granted += int'(FreeSlotsForN);
            dut_cycles++;
            AllocPopCount = FreeSlotsForN;
            tick();
        end
        AllocPopCount = '0;
        push(32'd32); check("drain.granted", 32'(dut_granted));
        push(32'd11); check("drain.cycles", 32'(dut_cycles));
        offer("empty", 0, 0, 0, 0, 0);

        // Pops against an empty list are ignored.
        AllocPopCount = 2'd3;
        tick();
        AllocPopCount = '0;
        offer("empty_pop", 0, 0, 0, 0, 0);

        // Single return becomes visible the following cycle, then popped again.
        retire3(3'b001, 32, 0, 0);
        tick();
        RetireEN = '0;
        offer("ret32", 1, 1, 32, 0, 0);
        AllocPopCount = 2'd1;
        tick();
        AllocPopCount = '0;
        offer("ret32_pop", 0, 0, 0, 0, 0);

        retire3(3'b111, 33, 34, 35);
        tick();
        offer("fill3", 3, 3, 33, 34, 35);

        // Returns with tag 0 rejected while popping two.
        retire3(3'b111, 40, 0, 50);
        AllocPopCount = 2'd2;
        tick();
        AllocPopCount = '0;
        RetireEN = '0;
        offer("ret_pop", 3, 3, 35, 40, 50);

        // Duplicate returns of an already-free tag leave state unchanged.
        retire3(3'b111, 35, 35, 35);
        tick();
        offer("dup_ret", 3, 3, 35, 40, 50);

        retire3(3'b010, 0, 63, 0);
        tick();
        RetireEN = '0;
        offer("ret63", 4, 3, 35, 40, 50);

        AllocPopCount = 2'd3;
        tick();
        offer("pop3", 1, 1, 63, 0, 0);
        tick();
        AllocPopCount = '0;
        offer("pop_clamp", 0, 0, 0, 0, 0);

        // Recovery rebuilds from the map; concurrent returns and pops are overridden.
        for (int i = 0; i < ARCH_COUNT; i++)
            archi_maptable[i] = TW'(i + 32);
        BPRecoverEN = 1'b1;
        AllocPopCount = 2'd3;
        retire3(3'b111, 40, 41, 42);
        tick();
        BPRecoverEN = 1'b0;
        AllocPopCount = '0;
        RetireEN = '0;
        offer("recover", 31, 3, 1, 2, 3);

        AllocPopCount = 2'd3;
        tick();
        tick();
        offer("redrain", 25, 3, 7, 8, 9);

        // Reset dominates every other input mid-drain.
        reset = 1'b1;
        BPRecoverEN = 1'b1;
        retire3(3'b111, 1, 2, 3);
        tick();
        reset = 1'b0;
        BPRecoverEN = 1'b0;
        RetireEN = '0;
        AllocPopCount = '0;
        offer("midreset", 32, 3, 32, 33, 34);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end
endmodule
